md_seq_ctrl: RTL and testbench

- Sequencing controller for the iterative multiply/divide unit fed from the ID/EX pipeline register.
- Detects a valid M-extension op leaving ID/EX, starts the unit, and counts its latency.
- Holds the PC, IF/ID and ID/EX registers stalled until the result is ready, then gives a one-cycle result strobe to the EX-stage writeback mux.
- Sits beside the hazard logic in EX; owns no arithmetic.

---
 rtl/md_pkg.sv | 33 +++
 rtl/md_seq_ctrl.sv | 104 ++++++++++
 tb/tb_md_seq_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared types for the M-extension pipeline path: op codes, the "no op"
// encoding and the sequencing FSM states.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  localparam logic [3:0] MD_OP_NONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // Codes 8-15 carry no operation.
  function automatic logic md_op_valid(input logic [3:0] op);
    return (op <= 4'd7);
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/md_seq_ctrl.sv
// Issue/latency sequencer for the iterative mul/div unit; stalls the front end
// until the result is ready. MD_DIVZ_FAST_EN: divide-by-zero finishes in one RUN cycle.
module md_seq_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] md_op_i,
  input  logic       opinvalid_i,
  input  logic       flush_i,
  input  logic       div_zero_i,
  output logic       md_start_o,
  output logic [2:0] md_op_o,
  output logic       md_kill_o,
  output logic       stall_o,
  output logic       md_busy_o,
  output logic       result_valid_o
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       md_op_q, md_op_d;
  logic             issue_s;
  logic [CNT_W-1:0] issue_cnt_s;

  assign issue_s = (state_q == IDLE) && md_op_valid(md_op_i) && !opinvalid_i && !flush_i;

`ifdef MD_DIVZ_FAST_EN
  assign issue_cnt_s = md_is_div(md_op_i) ? (div_zero_i ? {CNT_W{1'b0}} : DIV_CNT) : MUL_CNT;
`else
  logic unused_divz_s;
  assign unused_divz_s = div_zero_i;
  assign issue_cnt_s   = md_is_div(md_op_i) ? DIV_CNT : MUL_CNT;
`endif

  // State, latency counter and latched op register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      md_op_q <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_op_q <= md_op_d;
    end
  end

  // Next-state and output decode; RUN spans cnt = LAT-1 down to 0.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    md_op_d        = md_op_q;
    md_start_o     = 1'b0;
    md_kill_o      = 1'b0;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_s) begin
          md_start_o = 1'b1;
          stall_o    = 1'b1;
          md_op_d    = md_op_i[2:0];
          cnt_d      = issue_cnt_s;
          state_d    = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (flush_i) begin
          md_kill_o = 1'b1;
          cnt_d     = {CNT_W{1'b0}};
          state_d   = IDLE;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          stall_o = 1'b1;
          state_d = DONE;
        end else begin
          stall_o = 1'b1;
          cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        result_valid_o = !flush_i;
        state_d        = IDLE;
      end
      default: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  assign md_op_o   = md_op_q;
  assign md_busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_md_seq_ctrl.sv
// Directed bench for md_seq_ctrl with MUL_LAT=4, DIV_LAT=33; honours MD_DIVZ_FAST_EN.
module tb_md_seq_ctrl;
  import md_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] md_op_i;
  logic       opinvalid_i;
  logic       flush_i;
  logic       div_zero_i;
  logic       md_start_o;
  logic [2:0] md_op_o;
  logic       md_kill_o;
  logic       stall_o;
  logic       md_busy_o;
  logic       result_valid_o;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [2:0] exp_op  = 3'd0;
  logic [7:0] got_v, exp_v;

  md_seq_ctrl #(.MUL_LAT(4), .DIV_LAT(33)) dut (
    .clk(clk), .rst_n(rst_n), .md_op_i(md_op_i), .opinvalid_i(opinvalid_i),
    .flush_i(flush_i), .div_zero_i(div_zero_i), .md_start_o(md_start_o),
    .md_op_o(md_op_o), .md_kill_o(md_kill_o), .stall_o(stall_o),
    .md_busy_o(md_busy_o), .result_valid_o(result_valid_o)
  );

  always #5 clk = ~clk;

  // got/exp layout: {start, stall, result_valid, busy, kill, md_op[2:0]}
  task automatic test_reset();
    rst_n = 1'b0; md_op_i = MD_OP_NONE; opinvalid_i = 1'b0; flush_i = 1'b0; div_zero_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      got_v = {md_start_o, stall_o, result_valid_o, md_busy_o, md_kill_o, md_op_o};
      exp_v = 8'h00;
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got %b expected %b", c, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul(input logic [3:0] op);
    for (int c = 0; c < 8; c++) begin
      md_op_i = (c <= 5) ? op : MD_OP_NONE;
      @(negedge clk);
      got_v = {md_start_o, stall_o, result_valid_o, md_busy_o, md_kill_o, md_op_o};
      exp_v = {c == 0, c <= 4, c == 5, (c >= 1) && (c <= 5), 1'b0, exp_op};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL mul op=%0d cycle %0d: got %b expected %b", op, c, got_v, exp_v);
      end
      if (c == 0) exp_op = op[2:0];
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 72; c++) begin
      md_op_i = (c <= 34) ? 4'd5 : ((c <= 69) ? 4'd6 : MD_OP_NONE);
      @(negedge clk);
      got_v = {md_start_o, stall_o, result_valid_o, md_busy_o, md_kill_o, md_op_o};
      exp_v = {(c == 0) || (c == 35), (c <= 33) || ((c >= 35) && (c <= 68)),
               (c == 34) || (c == 69), ((c >= 1) && (c <= 34)) || ((c >= 36) && (c <= 69)),
               1'b0, exp_op};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", c, got_v, exp_v);
      end
      if (c == 0) exp_op = 3'd5;
      if (c == 35) exp_op = 3'd6;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    int lat;
`ifdef MD_DIVZ_FAST_EN
    lat = 1;
`else
    lat = 33;
`endif
    for (int c = 0; c < lat + 4; c++) begin
      md_op_i    = (c <= lat + 1) ? 4'd4 : MD_OP_NONE;
      div_zero_i = (c == 0);
      @(negedge clk);
      got_v = {md_start_o, stall_o, result_valid_o, md_busy_o, md_kill_o, md_op_o};
      exp_v = {c == 0, c <= lat, c == lat + 1, (c >= 1) && (c <= lat + 1), 1'b0, exp_op};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL div_zero cycle %0d: got %b expected %b", c, got_v, exp_v);
      end
      if (c == 0) exp_op = 3'd4;
      @(posedge clk); #1;
    end
    div_zero_i = 1'b0;
  endtask

  task automatic test_flush();
    // Flush while idle with a valid op: nothing issues.
    md_op_i = 4'd7; flush_i = 1'b1;
    @(negedge clk);
    got_v = {md_start_o, stall_o, result_valid_o, md_busy_o, md_kill_o, md_op_o};
    exp_v = {5'b00000, exp_op};
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL flush_idle: got %b expected %b", got_v, exp_v);
    end
    @(posedge clk); #1;
    for (int c = 0; c < 40; c++) begin
      md_op_i = (c <= 9) ? 4'd4 : MD_OP_NONE;
      flush_i = (c == 10);
      @(negedge clk);
      got_v = {md_start_o, stall_o, result_valid_o, md_busy_o, md_kill_o, md_op_o};
      exp_v = {c == 0, c <= 9, 1'b0, (c >= 1) && (c <= 10), c == 10, exp_op};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL flush_run cycle %0d: got %b expected %b", c, got_v, exp_v);
      end
      if (c == 0) exp_op = 3'd4;
      @(posedge clk); #1;
    end
    flush_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 8; c++) begin
      md_op_i = (c <= 3) ? 4'd3 : MD_OP_NONE;
      rst_n   = (c != 3);
      @(negedge clk);
      got_v = {md_start_o, stall_o, result_valid_o, md_busy_o, md_kill_o, md_op_o};
      exp_v = {c == 0, c <= 3, 1'b0, (c >= 1) && (c <= 3), 1'b0, exp_op};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid cycle %0d: got %b expected %b", c, got_v, exp_v);
      end
      if (c == 0) exp_op = 3'd3;
      if (c == 3) exp_op = 3'd0;
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_no_issue();
    // Bubble flag set, then out-of-range codes 8..14.
    for (int c = 0; c < 10; c++) begin
      opinvalid_i = (c < 3);
      md_op_i     = (c < 3) ? 4'd0 : 4'(c + 5);
      @(negedge clk);
      got_v = {md_start_o, stall_o, result_valid_o, md_busy_o, md_kill_o, md_op_o};
      exp_v = {5'b00000, exp_op};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL no_issue op=%0d inval=%0d: got %b expected %b", md_op_i, opinvalid_i, got_v, exp_v);
      end
      @(posedge clk); #1;
    end
    opinvalid_i = 1'b0;
    md_op_i     = MD_OP_NONE;
  endtask

  initial begin
    test_reset();
    test_mul(4'd0);
    test_mul(4'd3);
    test_back_to_back();
    test_div_zero();
    test_flush();
    test_reset_mid();
    test_no_issue();
    test_mul(4'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
